// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot encode a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first unmasked request scanning upward from ptr, mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; found=0 when no eligible request exists.
module rr_priority_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk ptr, ptr+1, ... (wrapping through the 2-bit add) and keep the first hit.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = ptr + SEL_W'(k);
      if (!found && req[w_cand] && !mask[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a 4:1 single-bit mux: grants one source, holds until done/drop/timeout.
// Latency: 1 cycle from sampled req to visible gnt; r is combinational from w and registered sel.
// Backpressure: losing requesters simply wait; the owner is released on done, req drop or HOLD_MAX.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic [N_REQ-1:0] w,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             r
);

  // Tenure count at which the owner is forced off (unused when HOLD_MAX is 0).
  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_busy_nxt;

  logic [SEL_W-1:0] w_pick_ptr;
  logic [N_REQ-1:0] w_pick_mask;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_timeout;
  logic             w_release;

  // One picker serves both cases: from IDLE it scans from ptr unmasked; on release it
  // scans from the slot after the owner with the owner excluded (no immediate re-grant).
  always_comb begin
    w_pick_ptr  = r_ptr;
    w_pick_mask = '0;
    if (r_state == GRANT) begin
      w_pick_ptr  = r_sel + 1'b1;
      w_pick_mask = onehot(r_sel);
    end
  end

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .mask  (w_pick_mask),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_timeout = (HOLD_MAX != 0) && (r_cnt == CNT_LAST);
  assign w_release = done || !req[r_sel] || w_timeout;

  // Next-state and next-output decode; everything holds unless a transition fires.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot(w_idx);
          w_sel_nxt   = w_idx;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + 1'b1;
          if (w_found) begin
            w_gnt_nxt = onehot(w_idx);
            w_sel_nxt = w_idx;
            w_cnt_nxt = '0;
          end else begin
            // sel deliberately keeps the old owner so the mux select never moves while idle.
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
          end
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;
  assign r    = r_busy ? w[r_sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter (HOLD_MAX=4): directed scenarios plus randomized run vs a reference model.
module tb_rr_mux_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] w;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       r;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: owner index (-1 = nobody), rotation start, tenure, last select.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;
  int m_sel   = 0;

  rr_mux_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done),
    .w     (w),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the arbitration rules to the inputs that the coming edge will sample.
  task automatic model_step();
    int nxt;
    int idx;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_ten = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && req[idx]) begin
          m_owner = idx; m_sel = idx; m_ten = 0;
        end
      end
    end else if (done || !req[m_owner] || (HOLD > 0 && m_ten == HOLD - 1)) begin
      m_ptr = (m_owner + 1) % 4;
      nxt = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (nxt < 0 && idx != m_owner && req[idx]) nxt = idx;
      end
      if (nxt >= 0) begin
        m_owner = nxt; m_sel = nxt; m_ten = 0;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_ten = (m_ten < 255) ? m_ten + 1 : 255;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b0000; done = 1'b0; w = 4'b0000;
    tick(); tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b sel=%0d busy=%b r=%b required all zero", gnt, sel, busy, r);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 4'($urandom);
      tick();
      n_cmp++;
      if ({gnt, sel, busy, r} !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_no_req[%0d]: gnt=%b sel=%0d busy=%b r=%b required all zero", i, gnt, sel, busy, r);
      end
    end
  endtask

  task automatic test_single_grant();
    req = 4'b0110; w = 4'b0010;
    tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%b sel=%0d busy=%b r=%b required 0010 1 1 1", gnt, sel, busy, r);
    end
    w = 4'b1101;
    #1;
    n_cmp++;
    if (r !== 1'b0) begin
      n_fail++;
      $display("FAIL r_follows_w: r=%b required 0", r);
    end
    w = 4'b0010;
  endtask

  task automatic test_back_to_back();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if ({gnt, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_handover: gnt=%b sel=%0d busy=%b required 0100 2 1", gnt, sel, busy);
    end
    req = 4'b0100; done = 1'b1; w = 4'b0100;
    tick();
    done = 1'b0;
    n_cmp++;
    if ({gnt, sel, busy, r} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: gnt=%b sel=%0d busy=%b r=%b required 0000 2 0 0", gnt, sel, busy, r);
    end
    tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_regrant: gnt=%b sel=%0d busy=%b r=%b required 0100 2 1 1", gnt, sel, busy, r);
    end
  endtask

  task automatic test_rotation();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    reset = 1'b1; done = 1'b0;
    tick();
    reset = 1'b0; req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << order[i];
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if ({gnt, sel, busy} !== {eg, 2'(order[i]), 1'b1}) begin
          n_fail++;
          $display("FAIL rotation[%0d.%0d]: gnt=%b sel=%0d busy=%b required %b %0d 1", i, c, gnt, sel, busy, eg, order[i]);
        end
        if (c == 0) tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1; done = 1'b0; req = 4'b0000;
    tick();
    reset = 1'b0; req = 4'b0001;
    tick();
    for (int c = 0; c < HOLD; c++) begin
      n_cmp++;
      if ({gnt, busy} !== {4'b0001, 1'b1}) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: gnt=%b busy=%b required 0001 1", c, gnt, busy);
      end
      tick();
    end
    n_cmp++;
    if ({gnt, sel, busy} !== {4'b0000, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_release: gnt=%b sel=%0d busy=%b required 0000 0 0", gnt, sel, busy);
    end
    tick();
    n_cmp++;
    if ({gnt, busy} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_regrant: gnt=%b busy=%b required 0001 1", gnt, busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    reset = 1'b1; req = 4'b0000;
    tick();
    reset = 1'b0; req = 4'b1000; w = 4'b1000;
    tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== {4'b1000, 2'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_pre: gnt=%b sel=%0d busy=%b r=%b required 1000 3 1 1", gnt, sel, busy, r);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_drop: gnt=%b sel=%0d busy=%b r=%b required all zero", gnt, sel, busy, r);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({gnt, sel, busy, r} !== {4'b1000, 2'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_regrant: gnt=%b sel=%0d busy=%b r=%b required 1000 3 1 1", gnt, sel, busy, r);
    end
  endtask

  task automatic test_random();
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_r;
    int         bad = 0;
    reset = 1'b1; done = 1'b0; req = 4'b0000;
    tick();
    for (int i = 0; i < 3000; i++) begin
      req   = 4'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      w     = 4'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      #1;
      e_gnt  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e_sel  = 2'(m_sel);
      e_busy = (m_owner >= 0);
      e_r    = (m_owner >= 0) ? w[m_sel] : 1'b0;
      n_cmp++;
      if ({gnt, sel, busy, r} !== {e_gnt, e_sel, e_busy, e_r}) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: gnt=%b sel=%0d busy=%b r=%b required %b %0d %b %b",
                   i, gnt, sel, busy, r, e_gnt, e_sel, e_busy, e_r);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; done = 1'b0; w = 4'b0000;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_rotation();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
